// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: walks one BCD digit at a time onto a shared
// decoder, blanks between slots, and swaps in newly loaded values only at frame boundaries.
module display_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   blank_mask,
    output logic                  load_ack,
    output logic [3:0]            digito,
    output logic [N_DIGITS-1:0]   anodos,
    output logic                  frame_done
);

    localparam int MAX_SLOT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW       = $clog2(MAX_SLOT + 1);
    localparam int IW       = $clog2(N_DIGITS);

    localparam logic [CW-1:0] SHOW_LOAD  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N_DIGITS - 1);
    localparam bit            HAS_BLANK  = (BLANK_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    typedef logic [N_DIGITS-1:0][3:0] digits_t;

    state_t                state, state_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    digits_t               disp_reg, disp_nxt;
    digits_t               pend_reg, pend_nxt;
    logic                  pend_vld, pend_vld_nxt;
    logic                  boundary;
    logic                  frame_end;
    logic                  slot_start;
    logic [3:0]            digito_nxt;
    logic [N_DIGITS-1:0]   anodos_nxt;

    // Slot sequencer: one shared down-counter, reloaded on every state entry.
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        boundary   = 1'b0;
        frame_end  = 1'b0;
        slot_start = 1'b0;

        case (state)
            IDLE: begin
                idx_nxt = '0;
                if (en) begin
                    slot_start = 1'b1;
                    if (HAS_BLANK) begin
                        state_nxt = BLANK;
                        cnt_nxt   = BLANK_LOAD;
                    end else begin
                        state_nxt = SHOW;
                        cnt_nxt   = SHOW_LOAD;
                    end
                end
            end

            BLANK: begin
                if (!en) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    boundary  = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt = SHOW;
                    cnt_nxt   = SHOW_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            SHOW: begin
                if (!en) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    boundary  = 1'b1;
                end else if (cnt == '0) begin
                    slot_start = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_nxt   = '0;
                        frame_end = 1'b1;
                        boundary  = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                    if (HAS_BLANK) begin
                        state_nxt = BLANK;
                        cnt_nxt   = BLANK_LOAD;
                    end else begin
                        state_nxt = SHOW;
                        cnt_nxt   = SHOW_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Double buffer: a load on the boundary (or while idle) bypasses the pending stage.
    always_comb begin
        disp_nxt     = disp_reg;
        pend_nxt     = pend_reg;
        pend_vld_nxt = pend_vld;

        if (load) begin
            pend_nxt = digits_in;
        end

        if (load && (boundary || state == IDLE)) begin
            disp_nxt     = digits_in;
            pend_vld_nxt = 1'b0;
        end else if (boundary && pend_vld) begin
            disp_nxt     = pend_reg;
            pend_vld_nxt = 1'b0;
        end else if (load) begin
            pend_vld_nxt = 1'b1;
        end
    end

    // Outputs are computed from next-state values so the registered copies line up
    // with the state they describe; the nibble is latched once per slot.
    always_comb begin
        digito_nxt = digito;
        if (state_nxt == IDLE) begin
            digito_nxt = '0;
        end else if (slot_start) begin
            digito_nxt = disp_nxt[idx_nxt];
        end

        anodos_nxt = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (state_nxt == SHOW && idx_nxt == IW'(i) && !blank_mask[i]) begin
                anodos_nxt[i] = 1'b0;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            disp_reg   <= '0;
            pend_reg   <= '0;
            pend_vld   <= 1'b0;
            load_ack   <= 1'b0;
            digito     <= '0;
            anodos     <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            disp_reg   <= disp_nxt;
            pend_reg   <= pend_nxt;
            pend_vld   <= pend_vld_nxt;
            load_ack   <= load;
            digito     <= digito_nxt;
            anodos     <= anodos_nxt;
            frame_done <= frame_end;
        end
    end

endmodule
